mips_multicycle_control: RTL and testbench

//  Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback over several clocks.

---
 rtl/mips_mc_pkg.sv | 106 ++++++++++
 rtl/mips_multicycle_control_if.sv | 41 ++++
 rtl/mips_alu_decoder.sv | 35 +++
 rtl/mips_multicycle_control.sv | 108 ++++++++++
 tb/tb_mips_multicycle_control.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings, opcode/funct
// constants, ALU control codes, mux select encodings and the per-state strobe decode.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEMADR    = 4'd3,
        ST_MEMRD     = 4'd4,
        ST_MEMWB     = 4'd5,
        ST_MEMWR     = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_ALUWB     = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_ADDIEX    = 4'd10,
        ST_ADDIWB    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_BRANCH_NE = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'd0,
        ALUOP_ADD   = 2'd1,
        ALUOP_SUB   = 2'd2,
        ALUOP_FUNCT = 2'd3
    } aluop_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    // Moore strobes for a state; FETCH irwrite/pcwrite are handled separately
    // because they follow mem_ready within the cycle.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH:     begin c.mem_req = 1'b1; c.alusrcb = SRCB_FOUR; c.pcsrc = PC_ALU; end
            ST_DECODE:    c.alusrcb = SRCB_IMMSH;
            ST_MEMADR:    begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
            ST_MEMRD:     begin c.mem_req = 1'b1; c.iord = 1'b1; end
            ST_MEMWB:     begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            ST_MEMWR:     begin c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1; end
            ST_EXECUTE:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_B; end
            ST_ALUWB:     begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            ST_BRANCH:    begin c.alusrca = 1'b1; c.branch = 1'b1; c.pcsrc = PC_ALUOUT; end
            ST_BRANCH_NE: begin c.alusrca = 1'b1; c.branch_ne = 1'b1; c.pcsrc = PC_ALUOUT; end
            ST_ADDIEX:    begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
            ST_ADDIWB:    c.regwrite = 1'b1;
            ST_JUMP:      begin c.pcwrite = 1'b1; c.pcsrc = PC_JUMP; end
            default:      c = '0;
        endcase
        return c;
    endfunction

    function automatic aluop_t state_aluop(input state_t s);
        case (s)
            ST_IDLE:                 return ALUOP_NONE;
            ST_EXECUTE:              return ALUOP_FUNCT;
            ST_BRANCH, ST_BRANCH_NE: return ALUOP_SUB;
            default:                 return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bus between the multicycle control FSM and the datapath/memory: master is the controller,
// slave is the datapath side that supplies instruction fields and the memory handshake.
interface mips_multicycle_control_if #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               mem_req;
    logic               iord;
    logic               irwrite;
    logic               memwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               pcwrite;
    logic               branch;
    logic               branch_ne;
    logic [2:0]         alucontrol;
    logic               illegal_op;
    logic [CNT_W-1:0]   retired_cnt;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, branch, branch_ne,
               alucontrol, illegal_op, retired_cnt, state_dbg
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, branch, branch_ne,
               alucontrol, illegal_op, retired_cnt, state_dbg
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: maps the FSM's aluop plus the R-type funct field to alucontrol.
// funct_ok reports whether funct is a supported R-type operation, independent of aluop.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_ok
);
    logic [2:0] rtype_ctl;

    always_comb begin
        funct_ok  = 1'b1;
        rtype_ctl = ALU_ADD;
        case (funct)
            FN_ADD:  rtype_ctl = ALU_ADD;
            FN_SUB:  rtype_ctl = ALU_SUB;
            FN_AND:  rtype_ctl = ALU_AND;
            FN_OR:   rtype_ctl = ALU_OR;
            FN_SLT:  rtype_ctl = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = rtype_ctl;
            default:     alucontrol = 3'b000;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls, illegal-op flagging and a retired counter.
// Define MC_BNE_EN to accept bne (opcode 000101) via the BRANCH_NE state; otherwise bne is illegal.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  bus
);
    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl_reg;
    logic [2:0]       alucontrol_reg;
    logic [2:0]       alucontrol_next;
    logic [CNT_W-1:0] retired_cnt_reg;
    logic             funct_ok;
    logic             illegal;
    logic             retire;
    logic             fetch_done;

    mips_alu_decoder u_alu_decoder (
        .aluop      (state_aluop(state_next)),
        .funct      (bus.funct),
        .alucontrol (alucontrol_next),
        .funct_ok   (funct_ok)
    );

    always_comb begin
        state_next = state_reg;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (bus.mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (funct_ok) state_next = ST_EXECUTE;
                        else          illegal    = 1'b1;
                    end
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_BEQ:       state_next = ST_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = ST_BRANCH_NE;
`endif
                    OP_ADDI:      state_next = ST_ADDIEX;
                    OP_J:         state_next = ST_JUMP;
                    default:      illegal    = 1'b1;
                endcase
                // Illegal instructions are dropped without retiring.
                if (illegal) state_next = ST_FETCH;
            end
            ST_MEMADR:  state_next = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   if (bus.mem_ready) state_next = ST_MEMWB;
            ST_MEMWR: begin
                if (bus.mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_EXECUTE: state_next = ST_ALUWB;
            ST_ADDIEX:  state_next = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_BRANCH_NE, ST_ADDIWB, ST_JUMP: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are valid from the start of each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ctrl_reg        <= '0;
            alucontrol_reg  <= 3'b000;
            retired_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ctrl_reg       <= state_ctrl(state_next);
            alucontrol_reg <= alucontrol_next;
            if (retire) retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
        end
    end

    assign fetch_done = (state_reg == ST_FETCH) && bus.mem_ready;

    assign bus.mem_req     = ctrl_reg.mem_req;
    assign bus.iord        = ctrl_reg.iord;
    assign bus.irwrite     = fetch_done;
    assign bus.memwrite    = ctrl_reg.memwrite;
    assign bus.memtoreg    = ctrl_reg.memtoreg;
    assign bus.regdst      = ctrl_reg.regdst;
    assign bus.regwrite    = ctrl_reg.regwrite;
    assign bus.alusrca     = ctrl_reg.alusrca;
    assign bus.alusrcb     = ctrl_reg.alusrcb;
    assign bus.pcsrc       = ctrl_reg.pcsrc;
    assign bus.pcwrite     = ctrl_reg.pcwrite | fetch_done;
    assign bus.branch      = ctrl_reg.branch;
    assign bus.branch_ne   = ctrl_reg.branch_ne;
    assign bus.alucontrol  = alucontrol_reg;
    assign bus.illegal_op  = illegal;
    assign bus.retired_cnt = retired_cnt_reg;
    assign bus.state_dbg   = STATE_W'(state_reg);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: each task walks one instruction cycle by cycle
// against hand-written expected strobes, mux selects, state and retired count.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(32), .STATE_W(4)) bus ();

    mips_multicycle_control #(.CNT_W(32), .STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Strobe bit positions in the observed strobe word.
    localparam logic [11:0] MREQ = 12'h001;
    localparam logic [11:0] IORD = 12'h002;
    localparam logic [11:0] IRW  = 12'h004;
    localparam logic [11:0] MWR  = 12'h008;
    localparam logic [11:0] M2R  = 12'h010;
    localparam logic [11:0] ASA  = 12'h020;
    localparam logic [11:0] RDST = 12'h040;
    localparam logic [11:0] RW   = 12'h080;
    localparam logic [11:0] PCW  = 12'h100;
    localparam logic [11:0] BR   = 12'h200;
    localparam logic [11:0] BNE  = 12'h400;
    localparam logic [11:0] ILL  = 12'h800;

    typedef struct {
        logic        rdy;
        logic [11:0] s;
        logic [10:0] f;
        logic [31:0] cnt;
    } row_t;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = 0;

    function automatic logic [11:0] obs_s();
        return {bus.illegal_op, bus.branch_ne, bus.branch, bus.pcwrite, bus.regwrite, bus.regdst,
                bus.alusrca, bus.memtoreg, bus.memwrite, bus.irwrite, bus.iord, bus.mem_req};
    endfunction

    function automatic logic [10:0] obs_f();
        return {bus.state_dbg, bus.alusrcb, bus.pcsrc, bus.alucontrol};
    endfunction

    function automatic row_t r(input logic rdy, input logic [11:0] s, input logic [3:0] st,
                               input logic [1:0] srcb, input logic [1:0] pcs,
                               input logic [2:0] alu, input logic [31:0] cnt);
        row_t x;
        x.rdy = rdy;
        x.s   = s;
        x.f   = {st, srcb, pcs, alu};
        x.cnt = cnt;
        return x;
    endfunction

    task automatic cyc(input logic rdy);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 6'b0;
        bus.funct = 6'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs_s() !== 12'h000 || obs_f() !== 11'h000 || bus.retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset: strobes=%h fields=%h cnt=%0d, expected 000/000/0",
                     obs_s(), obs_f(), bus.retired_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: state=%0d, expected 0", bus.state_dbg);
        end
        $display("reset: IDLE with all outputs low");
    endtask

    task automatic test_add();
        row_t rows[$];
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100000;
        rows.push_back(r(0, MREQ,            1, 2'b01, 2'b00, 3'b010, 0));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, 0));
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, 0));
        rows.push_back(r(1, ASA,              7, 2'b00, 2'b00, 3'b010, 0));
        rows.push_back(r(1, RW | RDST,        8, 2'b00, 2'b00, 3'b010, 0));
        foreach (rows[i]) begin
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL add[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        exp_cnt = 1;
        $display("add: fetch stall + 4 cycles");
    endtask

    task automatic test_rtype_functs();
        logic [5:0] fn  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ctl [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
        for (int k = 0; k < 4; k++) begin
            row_t rows[$];
            bus.opcode = 6'b000000;
            bus.funct  = fn[k];
            rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
            rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt));
            rows.push_back(r(1, ASA,              7, 2'b00, 2'b00, ctl[k], exp_cnt));
            rows.push_back(r(1, RW | RDST,        8, 2'b00, 2'b00, 3'b010, exp_cnt));
            foreach (rows[i]) begin
                cyc(rows[i].rdy);
                checks++;
                if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                    errors++;
                    $display("FAIL rtype_%b[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                             fn[k], i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
                end
            end
            exp_cnt++;
            $display("rtype funct=%b: alucontrol expected %b", fn[k], ctl[k]);
        end
    endtask

    task automatic test_lw_wait();
        row_t rows[$];
        bus.opcode = 6'b100011;
        bus.funct  = 6'b000000;
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ASA,              3, 2'b10, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(0, MREQ | IORD,      4, 2'b00, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(0, MREQ | IORD,      4, 2'b00, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(0, MREQ | IORD,      4, 2'b00, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, MREQ | IORD,      4, 2'b00, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, RW | M2R,         5, 2'b00, 2'b00, 3'b010, exp_cnt));
        foreach (rows[i]) begin
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL lw[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        exp_cnt++;
        $display("lw: 8 cycles with 3 wait states");
    endtask

    task automatic test_sw_wait();
        row_t rows[$];
        bus.opcode = 6'b101011;
        rows.push_back(r(1, MREQ | IRW | PCW,   1, 2'b01, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, 12'h000,            2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ASA,                3, 2'b10, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(0, MREQ | IORD | MWR,  6, 2'b00, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, MREQ | IORD | MWR,  6, 2'b00, 2'b00, 3'b010, exp_cnt));
        foreach (rows[i]) begin
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL sw[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        exp_cnt++;
        $display("sw: 5 cycles with 1 wait state");
    endtask

    task automatic test_branch_jump();
        row_t rows[$];
        // beq, then addi, then j, back to back
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ASA | BR,         9, 2'b00, 2'b01, 3'b110, exp_cnt));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt + 1));
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt + 1));
        rows.push_back(r(1, ASA,             10, 2'b10, 2'b00, 3'b010, exp_cnt + 1));
        rows.push_back(r(1, RW,              11, 2'b00, 2'b00, 3'b010, exp_cnt + 1));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt + 2));
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt + 2));
        rows.push_back(r(1, PCW,             12, 2'b00, 2'b10, 3'b010, exp_cnt + 2));
        foreach (rows[i]) begin
            if (i == 0) bus.opcode = 6'b000100;
            if (i == 3) bus.opcode = 6'b001000;
            if (i == 7) bus.opcode = 6'b000010;
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL beq_addi_j[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        exp_cnt += 3;
        $display("beq/addi/j: 3+4+3 cycles back to back");
    endtask

    task automatic test_illegal();
        row_t rows[$];
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ILL,              2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ILL,              2, 2'b11, 2'b00, 3'b010, exp_cnt));
        foreach (rows[i]) begin
            if (i == 0) begin bus.opcode = 6'b111111; bus.funct = 6'b100000; end
            if (i == 2) begin bus.opcode = 6'b000000; bus.funct = 6'b000000; end
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL illegal[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        $display("illegal: opcode 111111 and funct 000000 flagged, not retired");
    endtask

    task automatic test_bne();
        row_t rows[$];
        bus.opcode = 6'b000101;
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
`ifdef MC_BNE_EN
        rows.push_back(r(1, 12'h000,          2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, ASA | BNE,       13, 2'b00, 2'b01, 3'b110, exp_cnt));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt + 1));
`else
        rows.push_back(r(1, ILL,              2, 2'b11, 2'b00, 3'b010, exp_cnt));
        rows.push_back(r(1, MREQ | IRW | PCW, 1, 2'b01, 2'b00, 3'b010, exp_cnt));
`endif
        foreach (rows[i]) begin
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL bne[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        $display("bne: cycles checked, retired_cnt=%0d", bus.retired_cnt);
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        // Already in the DECODE of a bne/FETCH; finish with a lw stuck in MEMRD.
        bus.opcode = 6'b100011;
        rows.push_back(r(1, 12'h000,     2, 2'b11, 2'b00, 3'b010, bus.retired_cnt));
        rows.push_back(r(1, ASA,         3, 2'b10, 2'b00, 3'b010, bus.retired_cnt));
        rows.push_back(r(0, MREQ | IORD, 4, 2'b00, 2'b00, 3'b010, bus.retired_cnt));
        foreach (rows[i]) begin
            cyc(rows[i].rdy);
            checks++;
            if (obs_s() !== rows[i].s || obs_f() !== rows[i].f || bus.retired_cnt !== rows[i].cnt) begin
                errors++;
                $display("FAIL reset_mid_lw[%0d]: strobes=%h fields=%h cnt=%0d, expected strobes=%h fields=%h cnt=%0d",
                         i, obs_s(), obs_f(), bus.retired_cnt, rows[i].s, rows[i].f, rows[i].cnt);
            end
        end
        checks++;
        if (bus.retired_cnt === 32'd0) begin
            errors++;
            $display("FAIL reset_mid_precnt: cnt=0, expected nonzero before reset");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_s() !== 12'h000 || obs_f() !== 11'h000 || bus.retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: strobes=%h fields=%h cnt=%0d, expected 000/000/0",
                     obs_s(), obs_f(), bus.retired_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1);
        checks++;
        if (obs_s() !== (MREQ | IRW | PCW) || bus.state_dbg !== 4'd1 || bus.retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_refetch: strobes=%h state=%0d cnt=%0d, expected %h/1/0",
                     obs_s(), bus.state_dbg, bus.retired_cnt, MREQ | IRW | PCW);
        end
        $display("reset mid-MEMRD: outputs cleared asynchronously, refetch from IDLE");
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_functs();
        test_lw_wait();
        test_sw_wait();
        test_branch_jump();
        test_illegal();
        test_bne();
`ifndef MC_BNE_EN
        // bne left us in FETCH; step into DECODE of the lw used by the reset test.
        bus.opcode = 6'b100011;
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
